acc_shift_sequencer: RTL and testbench

Multi-cycle shift controller wrapped around the combinational 8-bit single-position shifter of the accumulator datapath. It holds the accumulator value and, on a start request, drives the shifter's data and direction inputs for the requested number of cycles. Each cycle it captures the shifter output back into the accumulator, then reports completion with carry and zero flags. It sits between the control unit (upstream) and the shifter/mux pair (downstream).

---
 rtl/acc_shift_sequencer_if.sv | 27 ++
 rtl/acc_shift_sequencer.sv | 86 ++++++++
 tb/tb_acc_shift_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/acc_shift_sequencer_if.sv
// Control-unit side bus of the accumulator shift sequencer: requests in, status out.
// The master modport is the control unit; the slave modport is the sequencer.
interface acc_shift_sequencer_if #(
  parameter int N  = 8,
  parameter int CW = 3
);
  logic          load;
  logic [N-1:0]  din;
  logic          start;
  logic          dir;
  logic [CW-1:0] amount;
  logic [N-1:0]  acc;
  logic          carry;
  logic          zero;
  logic          busy;
  logic          done;

  modport master (
    output load, din, start, dir, amount,
    input  acc, carry, zero, busy, done
  );

  modport slave (
    input  load, din, start, dir, amount,
    output acc, carry, zero, busy, done
  );
endinterface

// File: rtl/acc_shift_sequencer.sv
// Multi-cycle shift controller around an external single-position shifter.
// Holds the accumulator, replays it through the shifter once per cycle for the requested count.
module acc_shift_sequencer #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  acc_shift_sequencer_if.slave  ctl,
  output logic [N-1:0]          sh_d,
  output logic                  sh_control,
  input  logic [N-1:0]          sh_q
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [N-1:0]  acc_reg, acc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          carry_reg, carry_next;
  logic          dir_reg, dir_next;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    dir_next   = dir_reg;
    case (state_reg)
      IDLE: begin
        // load has priority over start; a simultaneous start is dropped.
        if (ctl.load) begin
          acc_next = ctl.din;
        end else if (ctl.start) begin
          dir_next   = ctl.dir;
          carry_next = 1'b0;
          cnt_next   = ctl.amount;
          state_next = (ctl.amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        acc_next   = sh_q;
        carry_next = dir_reg ? acc_reg[0] : acc_reg[N-1];
        cnt_next   = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      dir_reg   <= dir_next;
    end
  end

  // Shifter inputs come straight from registers so they hold for the whole SHIFT cycle.
  assign sh_d       = acc_reg;
  assign sh_control = dir_reg;

  assign ctl.acc   = acc_reg;
  assign ctl.carry = carry_reg;
  assign ctl.zero  = (acc_reg == '0);
  assign ctl.busy  = (state_reg != IDLE);
  assign ctl.done  = (state_reg == DONE);

endmodule

// File: tb/tb_acc_shift_sequencer.sv
// Directed bench for acc_shift_sequencer with a behavioural single-position shifter.
module tb_acc_shift_sequencer;
  localparam int N  = 8;
  localparam int CW = 3;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] sh_d;
  logic         sh_control;
  logic [N-1:0] sh_q;

  int n_checks = 0;
  int n_errors = 0;

  acc_shift_sequencer_if #(.N(N), .CW(CW)) ctl ();

  acc_shift_sequencer #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctl        (ctl.slave),
    .sh_d       (sh_d),
    .sh_control (sh_control),
    .sh_q       (sh_q)
  );

  // Zero-fill shifter: 0 = left, 1 = right.
  assign sh_q = sh_control ? (sh_d >> 1) : (sh_d << 1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load, start, then follow the operation to IDLE while checking its timing.
  task automatic run_op(input logic [7:0] d, input logic dr, input logic [2:0] amt,
                        input logic [7:0] exp_acc, input logic exp_carry, input bit inject);
    int idx;
    int busy_cnt;
    int done_cnt;
    int done_idx;
    int ctl_bad;
    @(negedge clk);
    ctl.load = 1'b1; ctl.din = d; ctl.start = 1'b0;
    @(negedge clk);
    ctl.load = 1'b0; ctl.start = 1'b1; ctl.dir = dr; ctl.amount = amt;
    @(negedge clk);
    ctl.start = 1'b0;
    idx = 0; busy_cnt = 0; done_cnt = 0; done_idx = -1; ctl_bad = 0;
    while (ctl.busy && idx < 40) begin
      busy_cnt++;
      if (ctl.done) begin
        done_cnt++;
        done_idx = idx;
      end
      if (idx < int'(amt) && sh_control !== dr) ctl_bad++;
      if (inject && idx == 3) begin
        ctl.load = 1'b1; ctl.start = 1'b1; ctl.din = 8'hFF; ctl.dir = ~dr; ctl.amount = 3'd2;
      end else begin
        ctl.load = 1'b0; ctl.start = 1'b0;
      end
      idx++;
      @(negedge clk);
    end
    ctl.load = 1'b0; ctl.start = 1'b0;
    check("idle_reached", {31'd0, ctl.busy}, 32'd0);
    check("busy_cycles", busy_cnt, int'(amt) + 1);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_idx, int'(amt));
    check("sh_control_stable", ctl_bad, 0);
    check("acc", {24'd0, ctl.acc}, {24'd0, exp_acc});
    check("carry", {31'd0, ctl.carry}, {31'd0, exp_carry});
    check("zero", {31'd0, ctl.zero}, {31'd0, (exp_acc == 8'h00)});
    $display("op din=0x%02h dir=%0d amount=%0d -> acc=0x%02h carry=%0d busy_cycles=%0d",
             d, dr, amt, ctl.acc, ctl.carry, busy_cnt);
  endtask

  initial begin
    int done_seen;
    reset_n = 1'b0;
    ctl.load = 1'b0; ctl.din = '0; ctl.start = 1'b0; ctl.dir = 1'b0; ctl.amount = '0;
    #2;
    check("rst_acc", {24'd0, ctl.acc}, 32'd0);
    check("rst_carry", {31'd0, ctl.carry}, 32'd0);
    check("rst_busy", {31'd0, ctl.busy}, 32'd0);
    check("rst_done", {31'd0, ctl.done}, 32'd0);
    check("rst_zero", {31'd0, ctl.zero}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(8'h96, 1'b0, 3'd3, 8'hB0, 1'b0, 1'b0);
    run_op(8'h96, 1'b1, 3'd2, 8'h25, 1'b1, 1'b0);
    run_op(8'h80, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0);
    run_op(8'h5A, 1'b0, 3'd0, 8'h5A, 1'b0, 1'b0);
    run_op(8'h01, 1'b0, 3'd7, 8'h80, 1'b0, 1'b1);

    // load and start together in IDLE: load wins, no shift begins
    @(negedge clk);
    ctl.load = 1'b1; ctl.start = 1'b1; ctl.din = 8'h33; ctl.dir = 1'b0; ctl.amount = 3'd4;
    @(negedge clk);
    ctl.load = 1'b0; ctl.start = 1'b0;
    check("ld_st_busy", {31'd0, ctl.busy}, 32'd0);
    check("ld_st_acc", {24'd0, ctl.acc}, 32'h33);
    @(negedge clk);
    check("ld_st_busy_later", {31'd0, ctl.busy}, 32'd0);
    check("ld_st_acc_later", {24'd0, ctl.acc}, 32'h33);
    $display("op load+start din=0x33 -> acc=0x%02h busy=%0d", ctl.acc, ctl.busy);

    // asynchronous reset in the middle of a 5-shift operation
    @(negedge clk);
    ctl.load = 1'b1; ctl.din = 8'h96;
    @(negedge clk);
    ctl.load = 1'b0; ctl.start = 1'b1; ctl.dir = 1'b0; ctl.amount = 3'd5;
    @(negedge clk);
    ctl.start = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'd0, ctl.busy}, 32'd1);
    check("mid_carry", {31'd0, ctl.carry}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_acc", {24'd0, ctl.acc}, 32'd0);
    check("abort_busy", {31'd0, ctl.busy}, 32'd0);
    check("abort_carry", {31'd0, ctl.carry}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ctl.done) done_seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ctl.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    $display("op reset abort -> acc=0x%02h busy=%0d done_seen=%0d", ctl.acc, ctl.busy, done_seen);

    run_op(8'hC3, 1'b1, 3'd5, 8'h06, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
